// File: rtl/reed_solomon_decoder_feed_ctrl.sv
// Job sequencer feeding the RS decoder core from a 64-byte-in / 1-byte-out FIFO.
// Admits a line only when all 64 bytes fit; frames CW_LEN-byte codewords, drains pad bytes of the last line.
module reed_solomon_decoder_feed_ctrl #(
   parameter int DEPTH  = 512,
   parameter int CW_LEN = 255
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [15:0]            cfg_num_cw,
   output logic                   busy,
   output logic                   done,
   input  logic                   line_valid,
   input  logic [511:0]           line_data,
   output logic                   line_ready,
   output logic [511:0]           fifo_enq_data,
   output logic                   fifo_enq_en,
   input  logic [$clog2(DEPTH):0] fifo_counter,
   input  logic [7:0]             fifo_deq_data,
   input  logic                   fifo_not_empty,
   output logic                   fifo_deq_en,
   output logic                   dec_valid,
   output logic                   dec_sop,
   output logic                   dec_eop,
   output logic [7:0]             dec_data,
   input  logic                   dec_ready
);
   localparam int               CNT_W     = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0] ENQ_LIMIT = CNT_W'(DEPTH - 64);
   localparam logic [15:0]      CW_LAST   = 16'(CW_LEN - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t      state_q;
   logic        busy_q;
   logic        done_q;
   logic [31:0] lines_left_q, lines_left_d;
   logic [5:0]  pad_left_q, pad_left_d;
   logic [15:0] cw_byte_q, cw_byte_d;
   logic [15:0] cw_left_q, cw_left_d;

   logic [31:0] total;
   logic [31:0] lines_calc;
   logic [5:0]  pad_calc;
   logic        in_job;
   logic        pop_cw;
   logic        pop_pad;
   logic        cw_wrap;
   logic        last_cw_pop;
   logic        last_pad_pop;

   // Job geometry; pad is the distance from total up to the next 64-byte boundary.
   always_comb begin
      total      = 32'(cfg_num_cw) * 32'(CW_LEN);
      lines_calc = (total + 32'd63) >> 6;
      pad_calc   = 6'(32'd0 - total);
   end

   always_comb begin
      in_job        = (state_q == S_RUN) || (state_q == S_DRAIN);
      line_ready    = in_job && (lines_left_q != 32'd0) && (fifo_counter <= ENQ_LIMIT);
      fifo_enq_en   = line_valid && line_ready;
      fifo_enq_data = line_data;

      dec_valid   = (state_q == S_RUN) && fifo_not_empty && (cw_left_q != 16'd0);
      dec_sop     = dec_valid && (cw_byte_q == 16'd0);
      dec_eop     = dec_valid && (cw_byte_q == CW_LAST);
      dec_data    = fifo_deq_data;
      pop_cw      = dec_valid && dec_ready;
      pop_pad     = (state_q == S_DRAIN) && fifo_not_empty;
      fifo_deq_en = pop_cw || pop_pad;

      cw_wrap      = pop_cw && (cw_byte_q == CW_LAST);
      last_cw_pop  = cw_wrap && (cw_left_q == 16'd1);
      last_pad_pop = pop_pad && (pad_left_q == 6'd1);
   end

   always_comb begin
      lines_left_d = lines_left_q;
      pad_left_d   = pad_left_q;
      cw_byte_d    = cw_byte_q;
      cw_left_d    = cw_left_q;
      if (fifo_enq_en) begin
         lines_left_d = lines_left_q - 32'd1;
      end
      if (pop_pad) begin
         pad_left_d = pad_left_q - 6'd1;
      end
      if (cw_wrap) begin
         cw_byte_d = 16'd0;
         cw_left_d = cw_left_q - 16'd1;
      end else if (pop_cw) begin
         cw_byte_d = cw_byte_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         lines_left_q <= 32'd0;
         pad_left_q   <= 6'd0;
         cw_byte_q    <= 16'd0;
         cw_left_q    <= 16'd0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  lines_left_q <= lines_calc;
                  pad_left_q   <= pad_calc;
                  cw_byte_q    <= 16'd0;
                  cw_left_q    <= cfg_num_cw;
                  busy_q       <= 1'b1;
                  if (cfg_num_cw == 16'd0) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               lines_left_q <= lines_left_d;
               cw_byte_q    <= cw_byte_d;
               cw_left_q    <= cw_left_d;
               if (last_cw_pop) begin
                  if (pad_left_q != 6'd0) begin
                     state_q <= S_DRAIN;
                  end else begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end
               end
            end
            S_DRAIN: begin
               // Every line is already in the FIFO here, so only pad bytes remain.
               lines_left_q <= lines_left_d;
               pad_left_q   <= pad_left_d;
               if (last_pad_pop) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_reed_solomon_decoder_feed_ctrl.sv
// Bench for reed_solomon_decoder_feed_ctrl: behavioural byte FIFO, line driver and byte scoreboard.
module tb_reed_solomon_decoder_feed_ctrl;
   localparam int DEPTH  = 512;
   localparam int CW_LEN = 255;
   localparam int CNT_W  = $clog2(DEPTH) + 1;
   localparam int AW     = $clog2(DEPTH);

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             start = 1'b0;
   logic [15:0]      cfg_num_cw = 16'd0;
   logic             busy, done;
   logic             line_valid = 1'b0;
   logic [511:0]     line_data = '0;
   logic             line_ready;
   logic [511:0]     fifo_enq_data;
   logic             fifo_enq_en;
   logic [CNT_W-1:0] fifo_counter;
   logic [7:0]       fifo_deq_data;
   logic             fifo_not_empty;
   logic             fifo_deq_en;
   logic             dec_valid, dec_sop, dec_eop;
   logic [7:0]       dec_data;
   logic             dec_ready = 1'b0;

   int total_cmp = 0;
   int bad_cmp   = 0;

   always #5 clk = ~clk;

   reed_solomon_decoder_feed_ctrl #(.DEPTH(DEPTH), .CW_LEN(CW_LEN)) dut (
      .clk(clk), .reset(reset), .start(start), .cfg_num_cw(cfg_num_cw),
      .busy(busy), .done(done),
      .line_valid(line_valid), .line_data(line_data), .line_ready(line_ready),
      .fifo_enq_data(fifo_enq_data), .fifo_enq_en(fifo_enq_en),
      .fifo_counter(fifo_counter), .fifo_deq_data(fifo_deq_data),
      .fifo_not_empty(fifo_not_empty), .fifo_deq_en(fifo_deq_en),
      .dec_valid(dec_valid), .dec_sop(dec_sop), .dec_eop(dec_eop),
      .dec_data(dec_data), .dec_ready(dec_ready)
   );

   // Behavioural 64-in / 1-out byte FIFO with registered occupancy.
   logic [7:0]       fmem [0:DEPTH-1];
   logic [AW-1:0]    wr_p, rd_p;
   logic [CNT_W-1:0] fcnt;
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_p <= '0;
         rd_p <= '0;
         fcnt <= '0;
      end else begin
         if (fifo_enq_en) begin
            for (int k = 0; k < 64; k++) fmem[wr_p + AW'(k)] <= fifo_enq_data[8*k +: 8];
            wr_p <= wr_p + AW'(64);
         end
         if (fifo_deq_en) rd_p <= rd_p + AW'(1);
         fcnt <= fcnt + (fifo_enq_en ? CNT_W'(64) : CNT_W'(0)) - (fifo_deq_en ? CNT_W'(1) : CNT_W'(0));
      end
   end
   assign fifo_counter   = fcnt;
   assign fifo_not_empty = (fcnt != '0);
   assign fifo_deq_data  = fmem[rd_p];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: samples on the falling edge, records what the next rising edge will commit.
   int n_lines = 0, n_ovf = 0, n_badpop = 0, n_pad = 0, n_pops = 0;
   int n_done = 0, n_lr = 0, n_proto = 0, last_pop_cyc = 0, done_cyc = 0;
   logic [9:0] obs_q[$];
   logic [9:0] exp_q[$];
   logic [511:0] line_mem[$];

   always @(negedge clk) begin
      if (fifo_enq_en !== (line_valid && line_ready)) n_proto++;
      if (fifo_enq_data !== line_data) n_proto++;
      if (fifo_enq_en) begin
         n_lines++;
         if (fifo_counter > CNT_W'(DEPTH - 64)) n_ovf++;
      end
      if (line_ready) n_lr++;
      if (dec_valid && dec_data !== fifo_deq_data) n_proto++;
      if (dec_valid && !dec_ready && fifo_deq_en) n_proto++;
      if (dec_valid && dec_ready) obs_q.push_back({dec_sop, dec_eop, dec_data});
      if (fifo_deq_en) begin
         n_pops++;
         last_pop_cyc = cyc;
         if (!fifo_not_empty) n_badpop++;
         if (!dec_valid) n_pad++;
      end
      if (done) begin
         n_done++;
         done_cyc = cyc;
      end
   end

   // Line / ready driver: presents line_mem in order, advancing on each accepted line.
   int job_base = 0;
   int drv_idx  = 0;
   int prev_idx = -1;
   bit drv_en   = 1'b0;
   bit rnd      = 1'b0;
   bit rdy_lvl  = 1'b0;
   always @(posedge clk) begin
      #1;
      drv_idx = n_lines - job_base;
      if (drv_en && drv_idx < line_mem.size()) begin
         if (!rnd || (line_valid && drv_idx == prev_idx)) line_valid = 1'b1;
         else line_valid = 1'($urandom_range(0, 1));
         line_data = line_mem[drv_idx];
         prev_idx  = drv_idx;
      end else begin
         line_valid = 1'b0;
         prev_idx   = -1;
      end
      dec_ready = rnd ? 1'($urandom_range(0, 1)) : rdy_lvl;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached, want summary before it");
      $fatal(1);
   end

   task automatic setup_job(input int n);
      int nl, tot, pos;
      logic [511:0] tmp;
      tot = n * CW_LEN;
      nl  = (tot + 63) / 64;
      line_mem.delete();
      exp_q.delete();
      obs_q.delete();
      for (int i = 0; i < nl; i++) begin
         for (int w = 0; w < 16; w++) tmp[32*w +: 32] = $urandom;
         line_mem.push_back(tmp);
      end
      for (int j = 0; j < tot; j++) begin
         tmp = line_mem[j/64];
         pos = j % CW_LEN;
         exp_q.push_back({pos == 0, pos == CW_LEN - 1, tmp[8*(j%64) +: 8]});
      end
      job_base = n_lines;
   endtask

   task automatic pulse_start(input int n);
      @(posedge clk); #1;
      cfg_num_cw = 16'(n);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cfg_num_cw = 16'd0;
   endtask

   task automatic wait_done(input int d0, input int budget);
      int t;
      t = 0;
      while (n_done == d0 && t < budget) begin
         @(posedge clk);
         t++;
      end
      repeat (3) @(negedge clk);
   endtask

   function automatic int stream_errs();
      int e;
      e = 0;
      if (obs_q.size() != exp_q.size()) e++;
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
         if (obs_q[i] !== exp_q[i]) e++;
      return e;
   endfunction

   function automatic int flag_count(input int bitpos);
      int c;
      c = 0;
      for (int i = 0; i < obs_q.size(); i++) if (obs_q[i][bitpos]) c++;
      return c;
   endfunction

   task automatic test_reset();
      repeat (3) @(negedge clk);
      total_cmp++;
      if ({busy, done, line_ready, fifo_enq_en, fifo_deq_en, dec_valid, dec_sop, dec_eop} !== 8'b0) begin
         bad_cmp++;
         $display("FAIL reset_outputs: got %b want 00000000",
                  {busy, done, line_ready, fifo_enq_en, fifo_deq_en, dec_valid, dec_sop, dec_eop});
      end
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      total_cmp++;
      if ({busy, done, line_ready, dec_valid} !== 4'b0) begin
         bad_cmp++;
         $display("FAIL idle_after_reset: got %b want 0000", {busy, done, line_ready, dec_valid});
      end
   endtask

   task automatic test_one_cw();
      int l0, p0, d0;
      rnd = 0; rdy_lvl = 1;
      setup_job(1);
      l0 = n_lines; p0 = n_pad; d0 = n_done;
      drv_en = 1;
      pulse_start(1);
      total_cmp++;
      if (busy !== 1'b1) begin bad_cmp++; $display("FAIL busy_after_start: got %b want 1", busy); end
      total_cmp++;
      if (line_ready !== 1'b1) begin bad_cmp++; $display("FAIL first_line_ready: got %b want 1", line_ready); end
      wait_done(d0, 2000);
      total_cmp++;
      if (n_lines - l0 != 4) begin bad_cmp++; $display("FAIL one_cw_lines: got %0d want 4", n_lines - l0); end
      total_cmp++;
      if (stream_errs() != 0) begin
         bad_cmp++;
         $display("FAIL one_cw_stream: got %0d bad entries (%0d bytes) want 0 (255 bytes)", stream_errs(), obs_q.size());
      end
      total_cmp++;
      if (flag_count(9) != 1 || flag_count(8) != 1) begin
         bad_cmp++;
         $display("FAIL one_cw_sop_eop: got sop=%0d eop=%0d want 1/1", flag_count(9), flag_count(8));
      end
      total_cmp++;
      if (n_pad - p0 != 1) begin bad_cmp++; $display("FAIL one_cw_pad: got %0d want 1", n_pad - p0); end
      total_cmp++;
      if (n_done - d0 != 1) begin bad_cmp++; $display("FAIL one_cw_done: got %0d want 1", n_done - d0); end
      total_cmp++;
      if (fifo_counter !== '0) begin bad_cmp++; $display("FAIL one_cw_fifo_empty: got %0d want 0", fifo_counter); end
      total_cmp++;
      if (busy !== 1'b0) begin bad_cmp++; $display("FAIL one_cw_idle: busy got %b want 0", busy); end
      drv_en = 0;
   endtask

   task automatic test_two_cw();
      int l0, p0, d0;
      rnd = 0; rdy_lvl = 1;
      setup_job(2);
      l0 = n_lines; p0 = n_pad; d0 = n_done;
      drv_en = 1;
      pulse_start(2);
      wait_done(d0, 3000);
      total_cmp++;
      if (n_lines - l0 != 8) begin bad_cmp++; $display("FAIL two_cw_lines: got %0d want 8", n_lines - l0); end
      total_cmp++;
      if (stream_errs() != 0) begin bad_cmp++; $display("FAIL two_cw_stream: got %0d bad entries want 0", stream_errs()); end
      total_cmp++;
      if (flag_count(9) != 2 || flag_count(8) != 2) begin
         bad_cmp++;
         $display("FAIL two_cw_sop_eop: got sop=%0d eop=%0d want 2/2", flag_count(9), flag_count(8));
      end
      total_cmp++;
      if (n_pad - p0 != 2) begin bad_cmp++; $display("FAIL two_cw_pad: got %0d want 2", n_pad - p0); end
      total_cmp++;
      if (n_done - d0 != 1 || done_cyc != last_pop_cyc + 1) begin
         bad_cmp++;
         $display("FAIL two_cw_done_timing: got %0d dones at cycle %0d want 1 at cycle %0d",
                  n_done - d0, done_cyc, last_pop_cyc + 1);
      end
      drv_en = 0;
   endtask

   task automatic test_zero_job();
      int l0, q0, r0, d0;
      rnd = 0; rdy_lvl = 1;
      setup_job(0);
      l0 = n_lines; q0 = n_pops; r0 = n_lr; d0 = n_done;
      drv_en = 1;
      pulse_start(0);
      total_cmp++;
      if ({busy, done} !== 2'b11) begin bad_cmp++; $display("FAIL zero_busy_done: got %b want 11", {busy, done}); end
      @(posedge clk); #1;
      total_cmp++;
      if ({busy, done} !== 2'b00) begin bad_cmp++; $display("FAIL zero_end: got %b want 00", {busy, done}); end
      repeat (3) @(negedge clk);
      total_cmp++;
      if (n_lr != r0 || n_lines != l0 || n_pops != q0) begin
         bad_cmp++;
         $display("FAIL zero_activity: got ready=%0d lines=%0d pops=%0d want 0/0/0", n_lr - r0, n_lines - l0, n_pops - q0);
      end
      total_cmp++;
      if (n_done - d0 != 1) begin bad_cmp++; $display("FAIL zero_done: got %0d want 1", n_done - d0); end
      drv_en = 0;
   endtask

   task automatic test_backpressure();
      int l0, p0, d0, o0;
      rnd = 0; rdy_lvl = 0;
      setup_job(4);
      l0 = n_lines; p0 = n_pad; d0 = n_done; o0 = n_ovf;
      drv_en = 1;
      pulse_start(4);
      repeat (30) @(negedge clk);
      total_cmp++;
      if (n_lines - l0 != 8) begin bad_cmp++; $display("FAIL bp_lines_full: got %0d want 8", n_lines - l0); end
      total_cmp++;
      if (fifo_counter !== CNT_W'(512)) begin bad_cmp++; $display("FAIL bp_counter: got %0d want 512", fifo_counter); end
      total_cmp++;
      if (line_ready !== 1'b0) begin bad_cmp++; $display("FAIL bp_ready_low: got %b want 0", line_ready); end
      @(posedge clk); #1;
      rdy_lvl = 1;
      wait_done(d0, 4000);
      total_cmp++;
      if (n_lines - l0 != 16) begin bad_cmp++; $display("FAIL bp_lines_total: got %0d want 16", n_lines - l0); end
      total_cmp++;
      if (n_ovf != o0) begin bad_cmp++; $display("FAIL bp_no_overflow: got %0d early enqueues want 0", n_ovf - o0); end
      total_cmp++;
      if (stream_errs() != 0) begin bad_cmp++; $display("FAIL bp_stream: got %0d bad entries want 0", stream_errs()); end
      total_cmp++;
      if (n_pad - p0 != 4) begin bad_cmp++; $display("FAIL bp_pad: got %0d want 4", n_pad - p0); end
      total_cmp++;
      if (n_done - d0 != 1) begin bad_cmp++; $display("FAIL bp_done: got %0d want 1", n_done - d0); end
      drv_en = 0;
   endtask

   task automatic test_start_ignored();
      int l0, p0, d0;
      rnd = 0; rdy_lvl = 1;
      setup_job(2);
      l0 = n_lines; p0 = n_pad; d0 = n_done;
      drv_en = 1;
      pulse_start(2);
      repeat (20) @(negedge clk);
      @(posedge clk); #1;
      cfg_num_cw = 16'd7;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cfg_num_cw = 16'd0;
      wait_done(d0, 3000);
      total_cmp++;
      if (n_lines - l0 != 8) begin bad_cmp++; $display("FAIL restart_lines: got %0d want 8", n_lines - l0); end
      total_cmp++;
      if (stream_errs() != 0) begin bad_cmp++; $display("FAIL restart_stream: got %0d bad entries want 0", stream_errs()); end
      total_cmp++;
      if (n_pad - p0 != 2 || n_done - d0 != 1) begin
         bad_cmp++;
         $display("FAIL restart_end: got pad=%0d done=%0d want 2/1", n_pad - p0, n_done - d0);
      end
      drv_en = 0;
   endtask

   task automatic test_reset_mid_run();
      int l0, d0;
      rnd = 0; rdy_lvl = 1;
      setup_job(3);
      d0 = n_done;
      drv_en = 1;
      pulse_start(3);
      repeat (40) @(posedge clk);
      #1;
      reset = 1'b1;
      drv_en = 0;
      @(negedge clk);
      total_cmp++;
      if ({busy, done, line_ready, fifo_enq_en, fifo_deq_en, dec_valid, dec_sop, dec_eop} !== 8'b0) begin
         bad_cmp++;
         $display("FAIL midrun_reset_outputs: got %b want 00000000",
                  {busy, done, line_ready, fifo_enq_en, fifo_deq_en, dec_valid, dec_sop, dec_eop});
      end
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (4) @(negedge clk);
      total_cmp++;
      if (n_done != d0 || busy !== 1'b0) begin
         bad_cmp++;
         $display("FAIL midrun_no_done: got dones=%0d busy=%b want 0/0", n_done - d0, busy);
      end
      setup_job(1);
      l0 = n_lines; d0 = n_done;
      drv_en = 1;
      pulse_start(1);
      wait_done(d0, 2000);
      total_cmp++;
      if (n_lines - l0 != 4 || stream_errs() != 0 || n_done - d0 != 1) begin
         bad_cmp++;
         $display("FAIL after_reset_job: got lines=%0d bad=%0d done=%0d want 4/0/1", n_lines - l0, stream_errs(), n_done - d0);
      end
      drv_en = 0;
   endtask

   task automatic test_random();
      int l0, p0, d0;
      rnd = 1;
      setup_job(5);
      l0 = n_lines; p0 = n_pad; d0 = n_done;
      drv_en = 1;
      pulse_start(5);
      wait_done(d0, 20000);
      total_cmp++;
      if (n_lines - l0 != 20) begin bad_cmp++; $display("FAIL rnd_lines: got %0d want 20", n_lines - l0); end
      total_cmp++;
      if (stream_errs() != 0) begin
         bad_cmp++;
         $display("FAIL rnd_stream: got %0d bad entries (%0d bytes) want 0 (1275 bytes)", stream_errs(), obs_q.size());
      end
      total_cmp++;
      if (flag_count(9) != 5 || flag_count(8) != 5) begin
         bad_cmp++;
         $display("FAIL rnd_sop_eop: got sop=%0d eop=%0d want 5/5", flag_count(9), flag_count(8));
      end
      total_cmp++;
      if (n_pad - p0 != 5 || n_done - d0 != 1) begin
         bad_cmp++;
         $display("FAIL rnd_end: got pad=%0d done=%0d want 5/1", n_pad - p0, n_done - d0);
      end
      drv_en = 0;
      rnd = 0;
   endtask

   task automatic test_no_pad();
      int l0, p0, d0;
      rnd = 0; rdy_lvl = 1;
      setup_job(64);
      l0 = n_lines; p0 = n_pad; d0 = n_done;
      drv_en = 1;
      pulse_start(64);
      wait_done(d0, 20000);
      total_cmp++;
      if (n_lines - l0 != 255) begin bad_cmp++; $display("FAIL nopad_lines: got %0d want 255", n_lines - l0); end
      total_cmp++;
      if (stream_errs() != 0) begin bad_cmp++; $display("FAIL nopad_stream: got %0d bad entries want 0", stream_errs()); end
      total_cmp++;
      if (n_pad != p0) begin bad_cmp++; $display("FAIL nopad_pad: got %0d want 0", n_pad - p0); end
      total_cmp++;
      if (n_done - d0 != 1 || done_cyc != last_pop_cyc + 1) begin
         bad_cmp++;
         $display("FAIL nopad_done_timing: got %0d dones at cycle %0d want 1 at cycle %0d",
                  n_done - d0, done_cyc, last_pop_cyc + 1);
      end
      drv_en = 0;
   endtask

   task automatic test_protocol();
      total_cmp++;
      if (n_proto != 0) begin bad_cmp++; $display("FAIL port_relations: got %0d violations want 0", n_proto); end
      total_cmp++;
      if (n_badpop != 0 || n_ovf != 0) begin
         bad_cmp++;
         $display("FAIL fifo_safety: got empty_pops=%0d early_enq=%0d want 0/0", n_badpop, n_ovf);
      end
   endtask

   initial begin
      test_reset();
      test_one_cw();
      test_two_cw();
      test_zero_job();
      test_backpressure();
      test_start_ignored();
      test_reset_mid_run();
      test_random();
      test_no_pad();
      test_protocol();
      $display("test done: total=%0d bad=%0d", total_cmp, bad_cmp);
      $finish;
   end

endmodule

// File: doc/reed_solomon_decoder_feed_ctrl.md
# reed_solomon_decoder_feed_ctrl

Job sequencer between the 512-bit line source (memory read path) and the Reed-Solomon decoder core, built around the 64-byte-enqueue / 1-byte-dequeue byte FIFO. For each job it fetches exactly the number of lines holding `cfg_num_cw` codewords. It admits a line only when the FIFO has room for all 64 bytes, which prevents any overwrite of unread data. It frames the byte stream into `CW_LEN`-byte codewords with SOP/EOP and discards trailing pad bytes of the last line.

## Interface
- `DEPTH`, 512: byte capacity of the attached FIFO; power of two, at least 128, multiple of 64.
- `CW_LEN`, 255: codeword length in bytes, 1..65535.
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high
- `start`  in  1  job start pulse; sampled in IDLE only
- `cfg_num_cw`  in  16  codewords in job; sampled with `start`
- `busy`  out  1  job in progress (state ≠ IDLE)
- `done`  out  1  one-cycle pulse at job end
- `line_valid`  in  1  upstream line available
- `line_data`  in  512  line, byte i = bits [8i+7:8i]
- `line_ready`  out  1  line accepted when `line_valid && line_ready`
- `fifo_enq_data`  out  512  = `line_data`
- `fifo_enq_en`  out  1  = `line_valid && line_ready`
- `fifo_counter`  in  clog2(DEPTH)+1  FIFO occupancy in bytes
- `fifo_deq_data`  in  8  FIFO head byte (combinational)
- `fifo_not_empty`  in  1  FIFO holds ≥1 byte
- `fifo_deq_en`  out  1  pop head byte
- `dec_valid`, `dec_sop`, `dec_eop`  out  1 each  byte valid / first / last byte of codeword
- `dec_data`  out  8  = `fifo_deq_data`
- `dec_ready`  in  1  decoder accepts byte

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE + `start`:
  - Latch `total = cfg_num_cw*CW_LEN` (32 bit).
  - Latch `lines_left = ceil(total/64)` and `pad_left = lines_left*64 - total` (0..63).
  - Clear `cw_byte` (16 bit) and `cw_left = cfg_num_cw`.
  - If `cfg_num_cw == 0`, go to DONE; otherwise go to RUN.
- `start` outside IDLE is ignored.
- Enqueue side, RUN and DRAIN:
  - `line_ready = (lines_left != 0) && (fifo_counter <= DEPTH-64)`.
  - Each accepted line decrements `lines_left`.
  - The space check uses the registered occupancy only. A same-cycle pop merely adds slack.
- Dequeue side, RUN:
  - `dec_valid = fifo_not_empty && cw_left != 0`.
  - `fifo_deq_en = dec_valid && dec_ready`.
  - `dec_sop = dec_valid && cw_byte == 0`.
  - `dec_eop = dec_valid && cw_byte == CW_LEN-1`.
  - On each pop, `cw_byte` increments. At CW_LEN-1 it wraps to 0 and decrements `cw_left`.
  - The pop that takes `cw_left` to 0 moves the FSM to DRAIN if `pad_left != 0`, else to DONE.
- DRAIN:
  - `dec_valid = 0`; `fifo_deq_en = fifo_not_empty`; each pop decrements `pad_left`.
  - When `pad_left` reaches 0 (last pad pop), go to DONE.
- DONE: `done = 1` for one cycle, then go to IDLE.
- By construction all lines are enqueued before the final codeword byte, so `lines_left == 0` in DRAIN and DONE.

## Timing
- Reset values:
  - State IDLE and all counters 0.
  - `busy`, `done`, `line_ready`, `fifo_enq_en`, `fifo_deq_en`, `dec_valid`, `dec_sop`, `dec_eop` all 0.
- Reset is permitted mid-job. The block returns to IDLE immediately with no `done`. Flushing the FIFO is the owner's responsibility via the shared reset.
- `start` → `busy` high the next cycle. The first `line_ready` can assert in that cycle.
- Latency from line acceptance to first `dec_valid` is one cycle, via the FIFO registered counter.
- `line_ready`, `dec_valid` and `fifo_deq_en` are combinational from registered state and inputs. `dec_ready` → `fifo_deq_en` is a combinational path.
- Throughput is one byte per cycle at the output. The input is one line per 64 output bytes in steady state.
- Simultaneous enqueue and pop is allowed every cycle.
- `fifo_counter` reaching exactly DEPTH is legal. No enqueue occurs until it is ≤ DEPTH-64.
- Last pop, `done` timing:
  - No pad: `done` is asserted in the cycle after the last codeword pop.
  - With pad: `done` is asserted in the cycle after the last pad pop.

## Test plan
- `cfg_num_cw=1`, `CW_LEN=255`, `dec_ready=1` → exactly 4 lines accepted; 255 bytes in order; `dec_sop` on byte 0, `dec_eop` on byte 254; 1 pad byte popped with `dec_valid=0`; `done` pulses once; `fifo_counter` ends 0.
- `cfg_num_cw=2` → 8 lines, 510 bytes, two SOP/EOP pairs (bytes 0/254, 255/509), 2 pad bytes drained, `done`.
- `dec_ready=0`, `line_valid=1`, `cfg_num_cw=4` → exactly 8 lines accepted (`fifo_counter`=512), `line_ready=0` thereafter. Raise `dec_ready` → 9th line accepted only once `fifo_counter ≤ 448`; data order intact, no byte overwritten.
- `cfg_num_cw=0` → `busy` for one cycle, `done` pulse, no `line_ready`, no pops.
- `start` pulsed during RUN → ignored, job counts unchanged. Reset asserted mid-RUN → all outputs 0 next edge, IDLE, no `done`. New job then completes normally.
- Random `line_valid`/`dec_ready` toggling with `cfg_num_cw=5` → scoreboard matches 1275 bytes in order, 5 SOP/5 EOP, 20 lines, `done` once.
